// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared constants and the loader state type.
//   BYTE_W - input stream byte width
//   WORD_W - RAM word width
//   ADDR_W - RAM address width
//   DEPTH  - number of RAM words (legal word count 1..DEPTH)
package prog_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 18;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 9;

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    B0,
    B1,
    B2,
    WRITE,
    CHK,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/prog_loader_assembler.sv
// prog_loader_assembler: collects three stream bytes into one RAM word.
//   clock   in  system clock
//   reset   in  synchronous active-high reset
//   cap_b0  in  capture byte as word bits [17:16]
//   cap_b1  in  capture byte as word bits [15:8]
//   cap_b2  in  capture byte as bits [7:0] and register the full word
//   in_byte in  stream byte
//   hi_bad  out byte carries nonzero bits above the two word bits (B0 check)
//   word    out assembled word, updated only when the third byte lands
module prog_loader_assembler
  import prog_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cap_b0,
  input  logic              cap_b1,
  input  logic              cap_b2,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              hi_bad,
  output logic [WORD_W-1:0] word
);

  localparam int HI_W = WORD_W - 2 * BYTE_W;

  logic [HI_W-1:0]   hi_q;
  logic [BYTE_W-1:0] mid_q;
  logic [WORD_W-1:0] word_q;

  assign hi_bad = |in_byte[BYTE_W-1:HI_W];
  assign word   = word_q;

  // The output word only changes on the third byte, so a half-built word
  // is never visible on the RAM data bus.
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q   <= '0;
      mid_q  <= '0;
      word_q <= '0;
    end else begin
      if (cap_b0) hi_q  <= in_byte[HI_W-1:0];
      if (cap_b1) mid_q <= in_byte;
      if (cap_b2) word_q <= {hi_q, mid_q, in_byte};
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: writer side of the CPU program RAM. Takes a byte stream
// (header = word count N, then 3 bytes per word, MSB first) and writes
// N words to RAM addresses 0..N-1, holding the CPU until the load is good.
// Optional build macro: PROG_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte over all payload bytes.
//   clock    in  system clock
//   reset    in  synchronous active-high reset
//   start    in  begin a load (honoured in IDLE, DONE, ERR only)
//   in_data  in  stream byte
//   in_valid in  stream byte valid
//   in_ready out loader takes a byte this cycle
//   wr_en    out RAM write enable
//   wr_addr  out RAM write address
//   wr_data  out RAM write data
//   cpu_hold out CPU frozen
//   done     out load finished cleanly (sticky)
//   err      out load aborted (sticky)
//
// state | meaning
// IDLE  | after reset, waiting for start
// HDR   | waiting for word count byte
// B0    | waiting for word bits [17:16]
// B1    | waiting for word bits [15:8]
// B2    | waiting for word bits [7:0]
// WRITE | one-cycle RAM write of the assembled word
// CHK   | waiting for checksum byte (checksum build only)
// DONE  | load good, CPU released
// ERR   | load aborted, CPU held
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [BYTE_W-1:0] DEPTH_B = BYTE_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] count_q;
  logic              wr_en_q;
  logic              cpu_hold_q;
  logic              done_q;
  logic              err_q;
  logic              accept;
  logic              hi_bad;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q;
`endif

  // Ready is a pure decode of the state register: no path from in_valid.
`ifdef PROG_LOADER_CHECKSUM_EN
  assign in_ready = (state_q == HDR) || (state_q == B0) || (state_q == B1) ||
                    (state_q == B2)  || (state_q == CHK);
`else
  assign in_ready = (state_q == HDR) || (state_q == B0) || (state_q == B1) ||
                    (state_q == B2);
`endif

  assign accept   = in_valid && in_ready;
  assign wr_en    = wr_en_q;
  assign wr_addr  = addr_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;

  prog_loader_assembler u_asm (
    .clock   (clock),
    .reset   (reset),
    .cap_b0  (accept && (state_q == B0)),
    .cap_b1  (accept && (state_q == B1)),
    .cap_b2  (accept && (state_q == B2)),
    .in_byte (in_data),
    .hi_bad  (hi_bad),
    .word    (wr_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      wr_en_q    <= 1'b0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_q    <= HDR;
            addr_q     <= '0;
            count_q    <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        HDR: begin
          if (accept) begin
            // Compare on the full byte so e.g. 0x10 is rejected, not truncated.
            if ((in_data == '0) || (in_data > DEPTH_B)) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              count_q <= in_data[ADDR_W-1:0];
              addr_q  <= '0;
              state_q <= B0;
            end
          end
        end
        B0: begin
          if (accept) begin
            if (hi_bad) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= B1;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ in_data;
`endif
          end
        end
        B1: begin
          if (accept) begin
            state_q <= B2;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ in_data;
`endif
          end
        end
        B2: begin
          if (accept) begin
            state_q <= WRITE;
            wr_en_q <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ in_data;
`endif
          end
        end
        WRITE: begin
          if (addr_q == count_q - ONE_A) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_q    <= CHK;
`else
            state_q    <= DONE;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b1;
`endif
          end else begin
            addr_q  <= addr_q + ONE_A;
            state_q <= B0;
          end
        end
        CHK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
          if (accept) begin
            if (in_data == csum_q) begin
              state_q    <= DONE;
              cpu_hold_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
`else
          state_q <= ERR;
          err_q   <= 1'b1;
`endif
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [BYTE_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              cpu_hold;
  logic              done;
  logic              err;

  prog_loader dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [21:0] got_q[$];
  int          ready_in_write = 0;

  always @(negedge clock) begin
    if (wr_en === 1'b1) got_q.push_back({wr_addr, wr_data});
    if (wr_en === 1'b1 && in_ready === 1'b1) ready_in_write++;
  end

  // reference model state
  logic [7:0]  stim[$];
  logic [21:0] exp_w[$];
  bit          exp_done;
  bit          exp_err;
  int          exp_cons;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outcome of a stream from the loader's rules: header range, 3 bytes per
  // word with only the low 2 bits of the first byte used, optional XOR byte.
  task automatic model();
    int n;
    int x;
    exp_w.delete();
    exp_done = 0;
    exp_err  = 0;
    x        = 0;
    n        = int'(stim[0]);
    exp_cons = 1;
    if (n == 0 || n > DEPTH) begin
      exp_err = 1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      int b0, b1, b2, w;
      b0 = int'(stim[1 + 3 * k]);
      exp_cons++;
      if (b0 > 3) begin
        exp_err = 1;
        return;
      end
      b1 = int'(stim[2 + 3 * k]);
      b2 = int'(stim[3 + 3 * k]);
      exp_cons += 2;
      x = x ^ b0 ^ b1 ^ b2;
      w = b0 * 65536 + b1 * 256 + b2;
      exp_w.push_back({4'(k), 18'(w)});
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    exp_cons++;
    if (int'(stim[1 + 3 * n]) != x) begin
      exp_err = 1;
      return;
    end
`endif
    exp_done = 1;
  endtask

  task automatic add_csum(input bit corrupt);
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < stim.size(); i++) x = x ^ stim[i];
    stim.push_back(corrupt ? (x ^ 8'h01) : x);
`else
    if (corrupt) stim.push_back(8'h00);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clock);
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clock);
      t++;
    end
    if (in_ready !== 1'b1) begin
      chk("ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clock);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_load(input string tag, input int maxgap);
    model();
    got_q.delete();
    ready_in_write = 0;
    pulse_start();
    for (int i = 0; i < exp_cons; i++) begin
      send_byte(stim[i], int'($urandom_range(maxgap, 0)));
    end
    if (exp_err) chk({tag, "_err_now"}, {31'd0, err}, 32'd1);
    repeat (4) @(negedge clock);
    chk({tag, "_nwr"}, got_q.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got_q.size(); i++) begin
      chk({tag, "_wr"}, {10'd0, got_q[i]}, {10'd0, exp_w[i]});
    end
    chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, !exp_done});
    chk({tag, "_rdy_wr"}, ready_in_write, 0);
  endtask

  task automatic set_basic();
    stim = '{8'h02, 8'h03, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h05};
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clock);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wren", {31'd0, wr_en}, 32'd0);
    chk("rst_addr", {28'd0, wr_addr}, 32'd0);
    chk("rst_data", {14'd0, wr_data}, 32'd0);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // basic load, back-to-back bytes
    set_basic();
    add_csum(1'b0);
    run_load("basic", 0);
    chk("basic_w0", {10'd0, exp_w[0]}, {10'd0, 4'd0, 18'h3FFFF});

    // bad headers
    stim = '{8'h0A};
    run_load("hdr_0a", 0);
    stim = '{8'h00};
    run_load("hdr_00", 0);

    // bad first payload byte
    stim = '{8'h01, 8'h04, 8'h00, 8'h00};
    run_load("bad_b0", 0);

    // backpressure
    set_basic();
    add_csum(1'b0);
    run_load("gaps", 5);

    // reset after 4 accepted bytes of an N=2 load
    set_basic();
    got_q.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(stim[i], 0);
    repeat (2) @(negedge clock);
    chk("mid_nwr", got_q.size(), 1);
    if (got_q.size() > 0) chk("mid_w0", {10'd0, got_q[0]}, {10'd0, 4'd0, 18'h3FFFF});
    reset = 1'b1;
    @(negedge clock);
    chk("mid_hold", {31'd0, cpu_hold}, 32'd1);
    chk("mid_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b1;
    repeat (6) @(negedge clock);
    in_valid = 1'b0;
    chk("mid_nwr_after", got_q.size(), 1);
    chk("mid_idle_ready", {31'd0, in_ready}, 32'd0);

    // restart with N=1
    stim = '{8'h01, 8'h00, 8'h12, 8'h34};
    add_csum(1'b0);
    run_load("restart", 2);
    if (got_q.size() > 0) chk("restart_w0", {14'd0, got_q[0][17:0]}, 32'h01234);

`ifdef PROG_LOADER_CHECKSUM_EN
    stim = '{8'h01, 8'h01, 8'h23, 8'h45, 8'h67};
    run_load("csum_ok", 0);
    stim = '{8'h01, 8'h01, 8'h23, 8'h45, 8'h66};
    run_load("csum_bad", 0);
    if (got_q.size() > 0) chk("csum_bad_w0", {14'd0, got_q[0][17:0]}, 32'h12345);
`endif

    // randomized loads
    for (int it = 0; it < 25; it++) begin
      int r, n;
      r = int'($urandom_range(11, 0));
      if (r <= 9) n = r;
      else if (r == 10) n = 0;
      else n = int'($urandom_range(255, 10));
      stim.delete();
      stim.push_back(8'(n));
      for (int k = 0; k < DEPTH; k++) begin
        if ($urandom_range(15, 0) == 0) stim.push_back(8'($urandom_range(255, 4)));
        else stim.push_back(8'($urandom_range(3, 0)));
        stim.push_back(8'($urandom));
        stim.push_back(8'($urandom));
        if (k + 1 == n) break;
      end
      add_csum($urandom_range(7, 0) == 0);
      run_load("rand", int'($urandom_range(3, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Program/data loader: the writer side of the 9×18-bit RAM set that the 4-bit CPU reads.
- Receives a byte stream over a valid/ready handshake and assembles 18-bit words.
- Writes the words to consecutive RAM addresses through the RAM write port (WA/WD/wrEN).
- Holds the CPU while loading and releases it when the load completes without error.

Parameters:
- DEPTH, 9, number of RAM words; legal word count is 1..DEPTH
- WORD_W, 18, RAM word width
- ADDR_W, 4, RAM address width
- BYTE_W, 8, input stream byte width

Ports:
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; begins a load from IDLE, DONE or ERR
- in_data  in  BYTE_W  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle; decoded from state register only
- wr_en  out  1  RAM wrEN
- wr_addr  out  ADDR_W  RAM WA
- wr_data  out  WORD_W  RAM WD
- cpu_hold  out  1  1 = CPU PC/regs frozen
- done  out  1  load completed successfully; sticky
- err  out  1  load aborted; sticky

Behaviour:
- Reset values: state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, err=0. Internal count and checksum also clear.
- Reset and clock: synchronous reset, active-high, one clock (clock).
- Byte acceptance: a byte is accepted when in_valid && in_ready. in_ready=1 only in HDR, B0, B1, B2 (and CHK when the optional feature is enabled).
- State IDLE, DONE, ERR:
  - start → HDR; cpu_hold=1, done=0, err=0.
  - start is ignored in all other states (no restart mid-load).
- State HDR: accepted byte is the word count N.
  - N==0 or N>DEPTH → ERR.
  - Otherwise latch N, addr=0 → B0.
- State B0: accepted byte supplies word bits [17:16] from byte[1:0].
  - byte[7:2]!=0 → ERR.
  - Otherwise → B1.
- State B1: byte → bits [15:8] → B2.
- State B2: byte → bits [7:0] → WRITE. The assembled word is registered into wr_data on the same edge.
- State WRITE (in_ready=0):
  - wr_en=1 for exactly one cycle, wr_addr=addr.
  - Next: if addr==N-1 → DONE (or CHK); else addr+1 → B0.
- State DONE: cpu_hold=0, done=1.
- State ERR: cpu_hold=1, err=1, wr_en=0.
- Timing:
  - Latency from third-byte acceptance to wr_en is 1 cycle.
  - Minimum of 4 cycles per word with continuous in_valid.
  - in_valid gaps stall the FSM in its current state with no side effects.
- Address range: wr_addr never exceeds N-1, and the address counter never wraps.
- Abort: ERR and reset do not erase RAM words already written. Partially loaded words are never written.
- Reset mid-load: returns to IDLE with cpu_hold=1 on the next cycle. No wr_en is issued after reset.
- Priority: reset > start > stream.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - Running XOR of all payload bytes (not the header).
  - After the last WRITE, go to CHK and accept one byte.
  - Byte equals running XOR → DONE; otherwise → ERR.
  - The checksum register clears on start.
- Undefined: no CHK state, no checksum logic; the last WRITE goes directly to DONE.

Decomposition:
- Package prog_loader_pkg: state enum (IDLE, HDR, B0, B1, B2, WRITE, CHK, DONE, ERR); constants BYTE_W, WORD_W, ADDR_W, DEPTH.
- Sub-module prog_loader_assembler: byte-lane capture into an 18-bit word, plus the B0 upper-bit check. It drives no handshake.
- The FSM, counters and handshake live in prog_loader.

Test Plan:
- Basic load: start, bytes 02,03,FF,FF,00,00,05 → wr_en at addr0 data 0x3FFFF, then addr1 data 0x00005; done=1, cpu_hold=0, err=0.
- Bad header: start, header 0x0A (also repeat with 0x00) → err=1, cpu_hold=1, no wr_en ever asserted.
- Bad first byte: start, 01, then 0x04 → err=1 immediately after acceptance, no write.
- Backpressure: same stream as basic load with random in_valid gaps of 0–5 cycles → identical write sequence and values; in_ready never asserted in WRITE.
- Reset and restart:
  - Reset after 4 accepted bytes of an N=2 load → addr0 was written, no further wr_en, state IDLE.
  - A following start plus a full N=1 load (01,00,12,34) → addr0=0x01234, done=1.
- Checksum (PROG_LOADER_CHECKSUM_EN):
  - Stream 01,01,23,45 + 0x67 (01^23^45) → done=1.
  - Same stream with 0x66 → err=1, addr0 still written 0x12345.
